// File: rtl/audio_level_sequencer_pkg.sv
// Shared types and constants for the audio level sequencer: state encoding,
// level range and the preset recall table.
package audio_ctrl_pkg;

   localparam int unsigned LVL_W   = 3;
   localparam int unsigned LVL_MAX = (2 ** LVL_W) - 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_VOL  = 2'd1,
      RAMP_BASS = 2'd2
   } state_t;

   typedef struct packed {
      logic [LVL_W-1:0] vol;
      logic [LVL_W-1:0] bass;
   } preset_t;

   localparam preset_t PRESET_TBL [4] = '{
      '{vol: 3'd2, bass: 3'd2},
      '{vol: 3'd4, bass: 3'd3},
      '{vol: 3'd6, bass: 3'd5},
      '{vol: 3'd7, bass: 3'd1}
   };

endpackage

// File: rtl/audio_level_sequencer_if.sv
// Request/level bundle between the control front end and the level sequencer.
// The mute input exists only when MUTE_EN is defined.
interface audio_level_sequencer_if
   import audio_ctrl_pkg::*;
#(
   parameter int unsigned LVL_W = audio_ctrl_pkg::LVL_W
);
   logic             vol_up;
   logic             vol_dn;
   logic             bass_up;
   logic             bass_dn;
   logic             preset_ld;
   logic [1:0]       preset_idx;
`ifdef MUTE_EN
   logic             mute;
`endif
   logic [LVL_W-1:0] vol_lvl;
   logic [LVL_W-1:0] bass_lvl;
   logic             busy;
   logic             ack;

   modport master (
      output vol_up, vol_dn, bass_up, bass_dn, preset_ld, preset_idx,
`ifdef MUTE_EN
      output mute,
`endif
      input  vol_lvl, bass_lvl, busy, ack
   );

   modport slave (
      input  vol_up, vol_dn, bass_up, bass_dn, preset_ld, preset_idx,
`ifdef MUTE_EN
      input  mute,
`endif
      output vol_lvl, bass_lvl, busy, ack
   );

endinterface

// File: rtl/audio_level_sequencer_step_timer.sv
// Ramp pacing timer: tick is high during the STEP_DIV-th enabled cycle after clear,
// so a step taken on tick lands exactly STEP_DIV cycles after the clear.
module step_timer #(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clear) begin
         cnt_nxt = '0;
      end else if (enable) begin
         cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   // Tick is registered from the count the next cycle will hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (clear || enable) && (cnt_nxt == CNT_LAST);
      end
   end

endmodule

// File: rtl/audio_level_sequencer.sv
// Volume/bass level sequencer: arbitrates step and preset requests in IDLE, then ramps
// volume and bass one step per STEP_DIV cycles. Optional mute/fade-in under MUTE_EN.
module audio_level_sequencer
   import audio_ctrl_pkg::*;
#(
   parameter int unsigned LVL_W    = audio_ctrl_pkg::LVL_W,
   parameter int unsigned STEP_DIV = 4
) (
   input logic                   clock,
   input logic                   reset,
   audio_level_sequencer_if.slave bus
);
   localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LVL_MAX);

   state_t           state, state_nxt;
   logic [LVL_W-1:0] vol_q, vol_nxt, bass_q, bass_nxt;
   logic [LVL_W-1:0] vol_tgt, vol_tgt_nxt, bass_tgt, bass_tgt_nxt;
   logic             ack_q, ack_nxt, busy_q, busy_nxt;
   logic             tmr_clr, tmr_en, tick;
   logic             accept_ok;
   logic             vol_req, bass_req;

   function automatic logic [LVL_W-1:0] step_toward(input logic [LVL_W-1:0] lvl,
                                                    input logic [LVL_W-1:0] tgt);
      return (lvl < tgt) ? lvl + 1'b1 : lvl - 1'b1;
   endfunction

   step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (tmr_clr),
      .enable (tmr_en),
      .tick   (tick)
   );

   // Opposing up/down requests cancel each other.
   assign vol_req  = bus.vol_up ^ bus.vol_dn;
   assign bass_req = bus.bass_up ^ bus.bass_dn;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         vol_q    <= '0;
         bass_q   <= '0;
         vol_tgt  <= '0;
         bass_tgt <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         vol_q    <= vol_nxt;
         bass_q   <= bass_nxt;
         vol_tgt  <= vol_tgt_nxt;
         bass_tgt <= bass_tgt_nxt;
         ack_q    <= ack_nxt;
         busy_q   <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      vol_nxt      = vol_q;
      bass_nxt     = bass_q;
      vol_tgt_nxt  = vol_tgt;
      bass_tgt_nxt = bass_tgt;
      ack_nxt      = 1'b0;
      busy_nxt     = busy_q;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (accept_ok && (bus.preset_ld || vol_req || bass_req)) begin
               state_nxt = RAMP_VOL;
               ack_nxt   = 1'b1;
               busy_nxt  = 1'b1;
               tmr_clr   = 1'b1;
               if (bus.preset_ld) begin
                  vol_tgt_nxt  = LVL_W'(PRESET_TBL[bus.preset_idx].vol);
                  bass_tgt_nxt = LVL_W'(PRESET_TBL[bus.preset_idx].bass);
               end else if (vol_req) begin
                  if (bus.vol_up) vol_tgt_nxt = (vol_q == LVL_TOP) ? vol_q : vol_q + 1'b1;
                  else            vol_tgt_nxt = (vol_q == '0)      ? vol_q : vol_q - 1'b1;
               end else begin
                  if (bus.bass_up) bass_tgt_nxt = (bass_q == LVL_TOP) ? bass_q : bass_q + 1'b1;
                  else             bass_tgt_nxt = (bass_q == '0)      ? bass_q : bass_q - 1'b1;
               end
            end
         end
         RAMP_VOL: begin
            if (vol_q == vol_tgt) begin
               state_nxt = RAMP_BASS;
               tmr_clr   = 1'b1;
            end else begin
               tmr_en = 1'b1;
               if (tick) vol_nxt = step_toward(vol_q, vol_tgt);
            end
         end
         RAMP_BASS: begin
            if (bass_q == bass_tgt) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               tmr_clr   = 1'b1;
            end else begin
               tmr_en = 1'b1;
               if (tick) bass_nxt = step_toward(bass_q, bass_tgt);
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.bass_lvl = bass_q;
   assign bus.ack      = ack_q;

`ifdef MUTE_EN
   logic             mute_q, fade, fade_tick;
   logic [LVL_W-1:0] vol_out;

   step_timer #(.STEP_DIV(STEP_DIV)) u_fade_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (!fade),
      .enable (fade),
      .tick   (fade_tick)
   );

   // Output volume is forced to 0 while muted and fades back in after release.
   always_ff @(posedge clock) begin
      if (reset) begin
         mute_q  <= 1'b0;
         fade    <= 1'b0;
         vol_out <= '0;
      end else begin
         mute_q <= bus.mute;
         if (bus.mute) begin
            fade    <= 1'b0;
            vol_out <= '0;
         end else if (mute_q) begin
            fade    <= 1'b1;
            vol_out <= '0;
         end else if (fade) begin
            if (vol_out == vol_q)  fade    <= 1'b0;
            else if (fade_tick)    vol_out <= step_toward(vol_out, vol_q);
         end
      end
   end

   assign accept_ok   = !fade;
   assign bus.vol_lvl = (mute_q || fade) ? vol_out : vol_q;
   assign bus.busy    = busy_q | fade;
`else
   assign accept_ok   = 1'b1;
   assign bus.vol_lvl = vol_q;
   assign bus.busy    = busy_q;
`endif

endmodule

// File: tb/tb_audio_level_sequencer.sv
// Directed bench for audio_level_sequencer (STEP_DIV=4); mute checks run when MUTE_EN is defined.
module tb_audio_level_sequencer;
   logic clock = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   audio_level_sequencer_if #(.LVL_W(3)) bus ();

   audio_level_sequencer #(.LVL_W(3), .STEP_DIV(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic clear_reqs();
      bus.vol_up = 1'b0; bus.vol_dn = 1'b0; bus.bass_up = 1'b0; bus.bass_dn = 1'b0;
      bus.preset_ld = 1'b0; bus.preset_idx = 2'd0;
   endtask

   // One-cycle request pulse; returns just after the sampling edge.
   task automatic pulse(input logic vu, input logic vd, input logic bu, input logic bd,
                        input logic pl, input logic [1:0] idx);
      bus.vol_up = vu; bus.vol_dn = vd; bus.bass_up = bu; bus.bass_dn = bd;
      bus.preset_ld = pl; bus.preset_idx = idx;
      cyc(1);
      clear_reqs();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 300) begin
         cyc(1);
         n++;
      end
      chk(tag, 8'(bus.busy), 8'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_reqs();
`ifdef MUTE_EN
      bus.mute = 1'b0;
`endif
      cyc(2);
      chk("rst_vol", 8'(bus.vol_lvl), 8'd0);
      chk("rst_bass", 8'(bus.bass_lvl), 8'd0);
      chk("rst_busy", 8'(bus.busy), 8'd0);
      chk("rst_ack", 8'(bus.ack), 8'd0);
      reset = 1'b0;
      cyc(1);

      // Single vol_up: first step 4 cycles after accept, idle 2 cycles later
      pulse(1, 0, 0, 0, 0, 2'd0);
      chk("t1_ack", 8'(bus.ack), 8'd1);
      chk("t1_busy", 8'(bus.busy), 8'd1);
      cyc(1);
      chk("t1_ack_pulse", 8'(bus.ack), 8'd0);
      cyc(2);
      chk("t1_vol_pre", 8'(bus.vol_lvl), 8'd0);
      cyc(1);
      chk("t1_vol_step", 8'(bus.vol_lvl), 8'd1);
      cyc(1);
      chk("t1_busy_bass", 8'(bus.busy), 8'd1);
      cyc(1);
      chk("t1_busy_done", 8'(bus.busy), 8'd0);

      // Preset 3 from (0,0): volume 0..7 at 4-cycle spacing, then bass 0->1
      do_reset();
      cyc(1);
      pulse(0, 0, 0, 0, 1, 2'd3);
      chk("t2_ack", 8'(bus.ack), 8'd1);
      cyc(3);
      chk("t2_vol_pre", 8'(bus.vol_lvl), 8'd0);
      cyc(1);
      chk("t2_vol_1", 8'(bus.vol_lvl), 8'd1);
      for (int k = 2; k <= 7; k++) begin
         cyc(4);
         chk($sformatf("t2_vol_%0d", k), 8'(bus.vol_lvl), 8'(k));
         chk($sformatf("t2_busy_%0d", k), 8'(bus.busy), 8'd1);
      end
      cyc(4);
      chk("t2_bass_pre", 8'(bus.bass_lvl), 8'd0);
      cyc(1);
      chk("t2_bass", 8'(bus.bass_lvl), 8'd1);
      chk("t2_busy_end", 8'(bus.busy), 8'd1);
      cyc(1);
      chk("t2_idle", 8'(bus.busy), 8'd0);

      // Saturated requests are acknowledged and take zero steps
      pulse(1, 0, 0, 0, 0, 2'd0);
      chk("t3_ack_sat", 8'(bus.ack), 8'd1);
      cyc(2);
      chk("t3_busy_sat", 8'(bus.busy), 8'd0);
      chk("t3_vol_sat", 8'(bus.vol_lvl), 8'd7);
      pulse(0, 0, 0, 1, 0, 2'd0);
      wait_idle("t3_idle_a");
      chk("t3_bass_dn", 8'(bus.bass_lvl), 8'd0);
      pulse(0, 0, 0, 1, 0, 2'd0);
      chk("t3_ack_bsat", 8'(bus.ack), 8'd1);
      wait_idle("t3_idle_b");
      chk("t3_bass_sat", 8'(bus.bass_lvl), 8'd0);

      // Preset beats simultaneous step requests; cancelled volume passes to bass
      pulse(1, 0, 1, 0, 1, 2'd0);
      chk("t4_ack", 8'(bus.ack), 8'd1);
      wait_idle("t4_idle_a");
      chk("t4_vol_preset", 8'(bus.vol_lvl), 8'd2);
      chk("t4_bass_preset", 8'(bus.bass_lvl), 8'd2);
      pulse(1, 1, 1, 0, 0, 2'd0);
      chk("t4_ack_void", 8'(bus.ack), 8'd1);
      wait_idle("t4_idle_b");
      chk("t4_vol_void", 8'(bus.vol_lvl), 8'd2);
      chk("t4_bass_up", 8'(bus.bass_lvl), 8'd3);

      // Requests while busy are dropped, not queued
      pulse(1, 0, 0, 0, 0, 2'd0);
      cyc(2);
      pulse(0, 1, 0, 0, 0, 2'd0);
      chk("t5_no_ack", 8'(bus.ack), 8'd0);
      wait_idle("t5_idle");
      chk("t5_vol", 8'(bus.vol_lvl), 8'd3);
      cyc(2);
      chk("t5_no_replay", 8'(bus.busy), 8'd0);
      chk("t5_vol_hold", 8'(bus.vol_lvl), 8'd3);

      // Reset mid-ramp at vol_lvl=3 discards the ramp
      do_reset();
      cyc(1);
      pulse(0, 0, 0, 0, 1, 2'd2);
      cyc(12);
      chk("t6_vol_mid", 8'(bus.vol_lvl), 8'd3);
      reset = 1'b1;
      cyc(1);
      chk("t6_vol_rst", 8'(bus.vol_lvl), 8'd0);
      chk("t6_bass_rst", 8'(bus.bass_lvl), 8'd0);
      chk("t6_busy_rst", 8'(bus.busy), 8'd0);
      reset = 1'b0;
      cyc(1);
      pulse(1, 0, 0, 0, 0, 2'd0);
      chk("t6_ack_after", 8'(bus.ack), 8'd1);
      wait_idle("t6_idle");
      chk("t6_vol_after", 8'(bus.vol_lvl), 8'd1);

`ifdef MUTE_EN
      // Mute at level 5, then fade back in 0..5
      pulse(0, 0, 0, 0, 1, 2'd1);
      wait_idle("t7_idle_a");
      pulse(1, 0, 0, 0, 0, 2'd0);
      wait_idle("t7_idle_b");
      chk("t7_vol_5", 8'(bus.vol_lvl), 8'd5);
      bus.mute = 1'b1;
      cyc(1);
      chk("t7_muted", 8'(bus.vol_lvl), 8'd0);
      cyc(3);
      chk("t7_muted_hold", 8'(bus.vol_lvl), 8'd0);
      bus.mute = 1'b0;
      cyc(1);
      chk("t7_fade_busy", 8'(bus.busy), 8'd1);
      chk("t7_fade_0", 8'(bus.vol_lvl), 8'd0);
      for (int k = 1; k <= 5; k++) begin
         cyc(4);
         chk($sformatf("t7_fade_%0d", k), 8'(bus.vol_lvl), 8'(k));
      end
      cyc(1);
      chk("t7_fade_done", 8'(bus.busy), 8'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
